// File: rtl/fifo_ram_ctrl.sv
// Circular-buffer controller for an external simple dual-port RAM with a registered read port.
// Latency: read data valid one cycle after an accepted read. Writes are refused when full and reads when empty.
module fifo_ram_ctrl #(
    parameter int P_DATA_WIDTH = 4,
    parameter int P_ADDR_DEPTH = 128,
    parameter int P_AFULL_TH   = 124,
    parameter int P_AEMPTY_TH  = 4,
    localparam int AW = $clog2(P_ADDR_DEPTH),
    localparam int CW = $clog2(P_ADDR_DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [P_DATA_WIDTH-1:0] i_wr_data,
    input  logic                    i_rd_en,
    output logic [P_DATA_WIDTH-1:0] o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic [CW-1:0]           o_data_cnt,
    output logic                    o_overflow,
    output logic                    o_underflow,
    output logic                    o_ram_ena,
    output logic [AW-1:0]           o_ram_waddr,
    output logic [P_DATA_WIDTH-1:0] o_ram_wdata,
    output logic                    o_ram_enb,
    output logic [AW-1:0]           o_ram_raddr,
    input  logic [P_DATA_WIDTH-1:0] i_ram_rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(P_ADDR_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(P_ADDR_DEPTH);
    localparam logic [CW-1:0] AFULL_C   = CW'(P_AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C  = CW'(P_AEMPTY_TH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc;
    logic          rd_acc;

    always_comb begin
        wr_acc = i_wr_en & ~full_q;
        rd_acc = i_rd_en & ~empty_q;

        wptr_d = wptr_q;
        if (wr_acc) begin
            wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + AW'(1);
        end
        rptr_d = rptr_q;
        if (rd_acc) begin
            rptr_d = (rptr_q == LAST_ADDR) ? '0 : rptr_q + AW'(1);
        end

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flags look at the post-update count so they are correct in the cycle they appear.
        full_d      = (count_d == DEPTH_C);
        empty_d     = (count_d == '0);
        afull_d     = (count_d >= AFULL_C);
        aempty_d    = (count_d <= AEMPTY_C);
        rd_valid_d  = rd_acc;
        overflow_d  = i_wr_en & full_q;
        underflow_d = i_rd_en & empty_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_ram_ena      = wr_acc;
    assign o_ram_waddr    = wptr_q;
    assign o_ram_wdata    = i_wr_data;
    assign o_ram_enb      = rd_acc;
    assign o_ram_raddr    = rptr_q;
    assign o_rd_data      = i_ram_rdata;
    assign o_rd_valid     = rd_valid_q;
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_data_cnt     = count_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Drives a depth-8 and a depth-6 controller with identical stimulus, each wired to its own RAM,
// and compares both against queue-based reference models.
module tb_fifo_ram_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] wr_data;

    logic       ena      [2];
    logic       enb      [2];
    logic [2:0] waddr    [2];
    logic [2:0] raddr    [2];
    logic [3:0] wdata    [2];
    logic [3:0] rdat     [2];
    logic [3:0] rd_data  [2];
    logic       rd_valid [2];
    logic       full     [2];
    logic       empty    [2];
    logic       afull    [2];
    logic       aempty   [2];
    logic       ovf      [2];
    logic       unf      [2];
    logic [3:0] cnt      [2];
    logic [3:0] cnt0;
    logic [2:0] cnt1;

    logic [3:0] mem0 [8];
    logic [3:0] mem1 [8];

    int nchk = 0;
    int nerr = 0;

    logic [3:0] m0[$];
    logic [3:0] m1[$];
    int depth  [2] = '{8, 6};
    int af_th  [2] = '{6, 4};
    int ae_th  [2] = '{2, 1};
    int wtot   [2];
    int rtot   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_ram_ctrl #(.P_DATA_WIDTH(4), .P_ADDR_DEPTH(8), .P_AFULL_TH(6), .P_AEMPTY_TH(2)) u_d8 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
        .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]), .o_full(full[0]), .o_empty(empty[0]),
        .o_almost_full(afull[0]), .o_almost_empty(aempty[0]), .o_data_cnt(cnt0),
        .o_overflow(ovf[0]), .o_underflow(unf[0]), .o_ram_ena(ena[0]), .o_ram_waddr(waddr[0]),
        .o_ram_wdata(wdata[0]), .o_ram_enb(enb[0]), .o_ram_raddr(raddr[0]), .i_ram_rdata(rdat[0])
    );

    fifo_ram_ctrl #(.P_DATA_WIDTH(4), .P_ADDR_DEPTH(6), .P_AFULL_TH(4), .P_AEMPTY_TH(1)) u_d6 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
        .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]), .o_full(full[1]), .o_empty(empty[1]),
        .o_almost_full(afull[1]), .o_almost_empty(aempty[1]), .o_data_cnt(cnt1),
        .o_overflow(ovf[1]), .o_underflow(unf[1]), .o_ram_ena(ena[1]), .o_ram_waddr(waddr[1]),
        .o_ram_wdata(wdata[1]), .o_ram_enb(enb[1]), .o_ram_raddr(raddr[1]), .i_ram_rdata(rdat[1])
    );

    assign cnt[0] = cnt0;
    assign cnt[1] = {1'b0, cnt1};

    always_ff @(posedge clk) begin
        if (ena[0]) mem0[waddr[0]] <= wdata[0];
        if (enb[0]) rdat[0] <= mem0[raddr[0]];
        if (ena[1]) mem1[waddr[1]] <= wdata[1];
        if (enb[1]) rdat[1] <= mem1[raddr[1]];
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s dut_depth%0d: observed %0d expected %0d", tag, depth[k], obs, exp);
        end
    endtask

    function automatic int msize(input int k);
        return (k == 0) ? m0.size() : m1.size();
    endfunction

    task automatic clear_models();
        m0.delete();
        m1.delete();
        for (int k = 0; k < 2; k++) begin
            wtot[k] = 0;
            rtot[k] = 0;
        end
    endtask

    task automatic chk_flags(input int k);
        int sz;
        sz = msize(k);
        chk("data_cnt", k, 32'(cnt[k]), 32'(sz));
        chk("full", k, 32'(full[k]), 32'(sz == depth[k]));
        chk("empty", k, 32'(empty[k]), 32'(sz == 0));
        chk("almost_full", k, 32'(afull[k]), 32'(sz >= af_th[k]));
        chk("almost_empty", k, 32'(aempty[k]), 32'(sz <= ae_th[k]));
    endtask

    // One clock of stimulus: RAM-side outputs checked before the edge, registered outputs after it.
    task automatic step(input logic wr, input logic rd, input logic [3:0] dat);
        logic       wacc [2];
        logic       racc [2];
        logic       wasfull [2];
        logic       wasempty [2];
        logic [3:0] expd;
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        wr_data = dat;
        #1;
        for (int k = 0; k < 2; k++) begin
            wasfull[k]  = (msize(k) == depth[k]);
            wasempty[k] = (msize(k) == 0);
            wacc[k] = wr && !wasfull[k];
            racc[k] = rd && !wasempty[k];
            chk("ram_ena", k, 32'(ena[k]), 32'(wacc[k]));
            chk("ram_enb", k, 32'(enb[k]), 32'(racc[k]));
            if (wacc[k]) begin
                chk("ram_waddr", k, 32'(waddr[k]), 32'(wtot[k] % depth[k]));
                chk("ram_wdata", k, 32'(wdata[k]), 32'(dat));
            end
            if (racc[k]) chk("ram_raddr", k, 32'(raddr[k]), 32'(rtot[k] % depth[k]));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            expd = 4'h0;
            if (racc[k]) expd = (k == 0) ? m0.pop_front() : m1.pop_front();
            if (wacc[k]) begin
                if (k == 0) m0.push_back(dat);
                else m1.push_back(dat);
            end
            wtot[k] += int'(wacc[k]);
            rtot[k] += int'(racc[k]);
            chk("rd_valid", k, 32'(rd_valid[k]), 32'(racc[k]));
            if (racc[k]) chk("rd_data", k, 32'(rd_data[k]), 32'(expd));
            chk("overflow", k, 32'(ovf[k]), 32'(wr && wasfull[k]));
            chk("underflow", k, 32'(unf[k]), 32'(rd && wasempty[k]));
            chk_flags(k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear_models();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = 4'h0;
        clear_models();

        // Reset then idle
        do_reset();
        for (int k = 0; k < 2; k++) begin
            chk_flags(k);
            chk("rst_rd_valid", k, 32'(rd_valid[k]), 32'd0);
            chk("rst_overflow", k, 32'(ovf[k]), 32'd0);
            chk("rst_underflow", k, 32'(unf[k]), 32'd0);
        end
        step(1'b0, 1'b0, 4'h0);

        // Write 1..8 back to back, then drain; depth-6 instance overflows on the last two
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 4'(i));
        chk("full_after_fill", 0, 32'(full[0]), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h0);
        chk("empty_after_drain", 0, 32'(empty[0]), 32'd1);

        // Full plus simultaneous write/read
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
        step(1'b1, 1'b1, 4'h5);
        chk("ovf_cnt_after", 0, 32'(cnt[0]), 32'd7);
        step(1'b0, 1'b0, 4'h0);

        // Empty plus simultaneous write/read, then read back the word
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'hA);
        chk("unf_cnt_after", 0, 32'(cnt[0]), 32'd1);
        step(1'b0, 1'b1, 4'h0);
        chk("unf_readback", 0, 32'(rd_data[0]), 32'hA);

        // Randomized traffic: fill-biased then drain-biased phases
        for (int i = 0; i < 400; i++) begin
            if (i < 200) step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 40, 4'($urandom_range(0, 15)));
            else step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 65, 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-fill at count 5
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
        chk("pre_rst_cnt", 0, 32'(cnt[0]), 32'd5);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        clear_models();
        for (int k = 0; k < 2; k++) chk_flags(k);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 4'h3);
        step(1'b0, 1'b1, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
